seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the team's hex-to-7-segment encoder.
- Snoops a multiplexed, active-low 7-segment display bus: segment lines plus per-digit anode enables.
- Debounces each (anode, segment) sample pair.
- Decodes the segment pattern back to a 4-bit hex value and assembles a NUM_DIGITS-digit word.
- Used for board loopback self-test and for bench checking of display drivers.

---
 rtl/seg7_scan_decoder.sv | 139 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each (anode, segment)
// pair and decodes committed patterns back into a NUM_DIGITS-digit hex word.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [6:0]              iSEG,
  input  logic [NUM_DIGITS-1:0]   iAN,
  input  logic                    iCLR_ERR,
  output logic [4*NUM_DIGITS-1:0] oVALUE,
  output logic [NUM_DIGITS-1:0]   oDIG_VALID,
  output logic                    oUPDATE,
  output logic                    oERR
);

  localparam int         SW       = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {TRACK, COMMIT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           samp_q, samp_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dv_q, dv_d;
  logic                    upd_q, upd_d;
  logic                    err_q, err_d;

  logic                    same;
  logic                    err_set;
  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic [4:0]              dec;
  int                      nzero;
  int                      idx;

  // Returns {valid, nibble}; valid is 0 for blank and for every unknown pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode_seg = {1'b1, 4'h0};
      7'b1111001: decode_seg = {1'b1, 4'h1};
      7'b0100100: decode_seg = {1'b1, 4'h2};
      7'b0110000: decode_seg = {1'b1, 4'h3};
      7'b0011001: decode_seg = {1'b1, 4'h4};
      7'b0010010: decode_seg = {1'b1, 4'h5};
      7'b0000010: decode_seg = {1'b1, 4'h6};
      7'b1111000: decode_seg = {1'b1, 4'h7};
      7'b0000000: decode_seg = {1'b1, 4'h8};
      7'b0011000: decode_seg = {1'b1, 4'h9};
      7'b0001000: decode_seg = {1'b1, 4'hA};
      7'b0000011: decode_seg = {1'b1, 4'hB};
      7'b1000110: decode_seg = {1'b1, 4'hC};
      7'b0100001: decode_seg = {1'b1, 4'hD};
      7'b0000110: decode_seg = {1'b1, 4'hE};
      7'b0001110: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = 5'h00;
    endcase
  endfunction

  always_comb begin
    samp_d = {iAN, iSEG};
    same   = (samp_d == samp_q);

    if (!same)                 cnt_d = 8'd1;
    else if (cnt_q == STABLE_C) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + 8'd1;

    // The commit fires from COMMIT using the held sample, so a change on the
    // commit edge itself does not cancel an already-stable interval.
    state_d = state_q;
    if (!same) begin
      state_d = TRACK;
    end else begin
      case (state_q)
        TRACK:   state_d = (cnt_d == STABLE_C) ? COMMIT : TRACK;
        COMMIT:  state_d = HOLD;
        default: state_d = HOLD;
      endcase
    end

    an_s  = samp_q[SW-1:7];
    seg_s = samp_q[6:0];
    dec   = decode_seg(seg_s);
    nzero = 0;
    idx   = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) begin
        nzero = nzero + 1;
        idx   = i;
      end
    end

    value_d = value_q;
    dv_d    = dv_q;
    upd_d   = 1'b0;
    err_set = 1'b0;
    if (state_q == COMMIT && nzero != 0) begin
      if (nzero != 1) begin
        err_set = 1'b1;
      end else if (dec[4]) begin
        value_d[4*idx +: 4] = dec[3:0];
        dv_d[idx]           = 1'b1;
        upd_d               = 1'b1;
      end else begin
        dv_d[idx] = 1'b0;
        err_set   = (seg_s != 7'h7F);
      end
    end
    err_d = (err_q & ~iCLR_ERR) | err_set;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= TRACK;
      samp_q  <= '1;
      cnt_q   <= '0;
      value_q <= '0;
      dv_q    <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      dv_q    <= dv_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign oVALUE     = value_q;
  assign oDIG_VALID = dv_q;
  assign oUPDATE    = upd_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scan scenarios plus random bus traffic,
// scored against a run-length reference model through an expectation queue.
module tb_seg7_scan_decoder;

  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     seg;
  logic [N-1:0]   an;
  logic           clr;
  logic [4*N-1:0] value;
  logic [N-1:0]   dig_valid;
  logic           upd;
  logic           err;

  seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .iCLK(clk), .iRST(rst), .iSEG(seg), .iAN(an), .iCLR_ERR(clr),
    .oVALUE(value), .oDIG_VALID(dig_valid), .oUPDATE(upd), .oERR(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic           upd;
    logic [4*N-1:0] val;
    logic [N-1:0]   dv;
    logic           err;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Segment pattern for each hex value, g..a, active-low.
  logic [6:0] enc [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: tracks how long the current pair has been on the bus and
  // whether that stable interval has already been committed.
  logic [4*N-1:0] m_val;
  logic [N-1:0]   m_dv;
  logic           m_err;
  logic           m_upd;
  logic [N+6:0]   m_prev;
  int             m_run;
  bit             m_done;

  task automatic model_step(input logic [N-1:0] a, input logic [6:0] s,
                            input logic c, input logic r);
    logic [N-1:0] pan, nan;
    logic [6:0]   pseg;
    logic         set;
    int           j, zi;
    set   = 1'b0;
    m_upd = 1'b0;
    if (r) begin
      m_val = '0; m_dv = '0; m_err = 1'b0;
      m_prev = '1; m_run = 0; m_done = 0;
    end else begin
      if (m_run >= S && !m_done) begin
        m_done = 1;
        pan  = m_prev[N+6:7];
        pseg = m_prev[6:0];
        nan  = ~pan;
        if ($countones(nan) > 1) begin
          set = 1'b1;
        end else if ($countones(nan) == 1) begin
          zi = 0;
          for (int i = 0; i < N; i++) if (nan[i]) zi = i;
          j = -1;
          for (int k = 0; k < 16; k++) if (enc[k] == pseg) j = k;
          if (j >= 0) begin
            m_val[4*zi +: 4] = j[3:0];
            m_dv[zi] = 1'b1;
            m_upd = 1'b1;
          end else begin
            m_dv[zi] = 1'b0;
            if (pseg != 7'h7F) set = 1'b1;
          end
        end
      end
      m_err = (m_err & ~c) | set;
      if ({a, s} == m_prev) m_run++;
      else begin
        m_prev = {a, s}; m_run = 1; m_done = 0;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [6:0] s, input int n,
                       input logic c, input logic r);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      an = a; seg = s; clr = c; rst = r;
      model_step(a, s, c, r);
      e.cyc = cyc + 1;
      e.upd = m_upd; e.val = m_val; e.dv = m_dv; e.err = m_err;
      q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL stale_expectation: cycle %0d expected at %0d", cyc, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("oUPDATE", 16'(upd), 16'(e.upd));
      check("oVALUE", 16'(value), 16'(e.val));
      check("oDIG_VALID", 16'(dig_valid), 16'(e.dv));
      check("oERR", 16'(err), 16'(e.err));
    end
  end

  initial begin
    int r, len, d;
    logic [N-1:0] a;
    logic [6:0]   s;
    rst = 1'b1; an = '1; seg = 7'h7F; clr = 1'b0;
    drive('1, 7'h7F, 2, 1'b0, 1'b1);
    drive('1, 7'h7F, 20, 1'b0, 1'b0);
    // single digit held long
    drive(4'b1110, enc[5], 55, 1'b0, 1'b0);
    // full scan 3, A, 0, F
    drive(4'b1110, enc[3], 8, 1'b0, 1'b0);
    drive(4'b1101, enc[10], 8, 1'b0, 1'b0);
    drive(4'b1011, enc[0], 8, 1'b0, 1'b0);
    drive(4'b0111, enc[15], 8, 1'b0, 1'b0);
    // glitch rejection on digit 1
    drive(4'b1101, enc[7], 8, 1'b0, 1'b0);
    drive(4'b1101, enc[8], 3, 1'b0, 1'b0);
    drive(4'b1101, enc[7], 8, 1'b0, 1'b0);
    drive(4'b1101, enc[8], 4, 1'b0, 1'b0);
    drive(4'b1101, enc[7], 6, 1'b0, 1'b0);
    // errors
    drive(4'b1100, enc[7], 6, 1'b0, 1'b0);
    drive(4'b1110, 7'b1010101, 6, 1'b0, 1'b0);
    drive('1, 7'h7F, 1, 1'b1, 1'b0);
    drive(4'b1011, 7'b1010101, 4, 1'b0, 1'b0);
    drive(4'b1011, 7'b1010101, 1, 1'b1, 1'b0);
    drive(4'b1011, 7'b1010101, 3, 1'b0, 1'b0);
    drive('1, 7'h7F, 1, 1'b1, 1'b0);
    drive('1, 7'h7F, 5, 1'b0, 1'b0);
    // load 1234 then reset mid-scan
    drive(4'b1110, enc[4], 8, 1'b0, 1'b0);
    drive(4'b1101, enc[3], 8, 1'b0, 1'b0);
    drive(4'b1011, enc[2], 8, 1'b0, 1'b0);
    drive(4'b0111, enc[1], 8, 1'b0, 1'b0);
    drive(4'b1110, enc[4], 2, 1'b0, 1'b0);
    drive(4'b1110, enc[4], 1, 1'b0, 1'b1);
    drive(4'b1110, enc[4], 6, 1'b0, 1'b0);
    // random traffic
    for (int t = 0; t < 300; t++) begin
      r   = $urandom_range(0, 9);
      len = $urandom_range(1, 9);
      d   = $urandom_range(0, N - 1);
      a   = '1;
      a[d] = 1'b0;
      s   = enc[$urandom_range(0, 15)];
      if (r == 6) s = 7'h7F;
      else if (r == 7) begin a = '1; s = 7'h7F; end
      else if (r == 8) a = N'($urandom);
      else if (r == 9) s = 7'($urandom);
      if ($urandom_range(0, 99) == 0) drive(a, s, 1, 1'b0, 1'b1);
      drive(a, s, len, ($urandom_range(0, 7) == 0), 1'b0);
    end
    drive('1, 7'h7F, 8, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
